// File: rtl/sap_control_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : sap_control_sequencer
//  Purpose  : Five-step T-state fetch/execute sequencer for the 8-bit
//             computer; latches the opcode nibble during fetch and decodes
//             the datapath load/output strobes from its own state.
//  Revision : 1.0 - initial release
// ============================================================================
module sap_control_sequencer #(
  parameter int NUM_STEPS = 5
) (
  input  logic       clk,
  input  logic       clear,
  input  logic       run,
  input  logic [7:0] data_bus,
  output logic       pc_out,
  output logic       pc_inc,
  output logic       mar_load,
  output logic       ram_out,
  output logic       ir_load,
  output logic       ir_out,
  output logic       a_load,
  output logic       a_out,
  output logic       b_load,
  output logic       alu_out,
  output logic       alu_sub,
  output logic       out_load,
  output logic       halted,
  output logic [2:0] t_state,
  output logic       instr_done
);

  typedef enum logic [2:0] {
    T0 = 3'd0,
    T1 = 3'd1,
    T2 = 3'd2,
    T3 = 3'd3,
    T4 = 3'd4
  } t_state_t;

  localparam logic [3:0] c_op_lda  = 4'b0001;
  localparam logic [3:0] c_op_add  = 4'b0010;
  localparam logic [3:0] c_op_sub  = 4'b0011;
  localparam logic [3:0] c_op_out  = 4'b1110;
  localparam logic [3:0] c_op_hlt  = 4'b1111;
  localparam logic [2:0] c_last    = 3'(NUM_STEPS - 1);

  t_state_t   r_t_state, w_t_state_next;
  logic [3:0] r_opcode,  w_opcode_next;
  logic       r_halted,  w_halted_next;

  // State registers; clear forces the fetch state without waiting for a clock.
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      r_t_state <= T0;
      r_opcode  <= 4'b0000;
      r_halted  <= 1'b0;
    end else begin
      r_t_state <= w_t_state_next;
      r_opcode  <= w_opcode_next;
      r_halted  <= w_halted_next;
    end
  end

  // Next state: advance the ring only on run-qualified edges while not halted.
  always_comb begin
    w_t_state_next = r_t_state;
    w_opcode_next  = r_opcode;
    w_halted_next  = r_halted;
    if (run && !r_halted) begin
      if (r_t_state == c_last) begin
        w_t_state_next = T0;
      end else begin
        w_t_state_next = t_state_t'(r_t_state + 3'd1);
      end
      if (r_t_state == T1) begin
        w_opcode_next = data_bus[7:4];
      end
      // HLT freezes the ring at T3 because halting blocks further advances.
      if (r_t_state == T2 && r_opcode == c_op_hlt) begin
        w_halted_next = 1'b1;
      end
    end
  end

  // Strobe decode from registered state only; halted masks everything.
  always_comb begin
    pc_out     = 1'b0;
    pc_inc     = 1'b0;
    mar_load   = 1'b0;
    ram_out    = 1'b0;
    ir_load    = 1'b0;
    ir_out     = 1'b0;
    a_load     = 1'b0;
    a_out      = 1'b0;
    b_load     = 1'b0;
    alu_out    = 1'b0;
    alu_sub    = 1'b0;
    out_load   = 1'b0;
    instr_done = 1'b0;
    if (!r_halted) begin
      case (r_t_state)
        T0: begin
          pc_out   = 1'b1;
          mar_load = 1'b1;
        end
        T1: begin
          ram_out = 1'b1;
          ir_load = 1'b1;
          pc_inc  = 1'b1;
        end
        T2: begin
          if (r_opcode == c_op_lda || r_opcode == c_op_add || r_opcode == c_op_sub) begin
            ir_out   = 1'b1;
            mar_load = 1'b1;
          end else if (r_opcode == c_op_out) begin
            a_out    = 1'b1;
            out_load = 1'b1;
          end
        end
        T3: begin
          if (r_opcode == c_op_lda) begin
            ram_out = 1'b1;
            a_load  = 1'b1;
          end else if (r_opcode == c_op_add || r_opcode == c_op_sub) begin
            ram_out = 1'b1;
            b_load  = 1'b1;
          end
        end
        T4: begin
          instr_done = 1'b1;
          if (r_opcode == c_op_add || r_opcode == c_op_sub) begin
            alu_out = 1'b1;
            a_load  = 1'b1;
            alu_sub = (r_opcode == c_op_sub);
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign halted  = r_halted;
  assign t_state = r_t_state;

endmodule
`default_nettype wire
